gshare_pht_predictor: RTL and testbench

//  Parametrised pattern-history-table branch predictor: 2^IDX_W saturating counters of
//  CTR_W bits, indexed bimodally (PC) or gshare (PC xor global history). Fetch-stage

---
 rtl/gshare_pht_if.sv | 29 ++
 rtl/gshare_pht_predictor.sv | 121 ++++++++++++
 tb/tb_gshare_pht_predictor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gshare_pht_if.sv
// Lookup/update/prediction bundle between the fetch/execute stages and the gshare predictor.
// Inputs are sampled on the rising clock edge; there is no backpressure beyond o_ready.
interface gshare_pht_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
);
  logic             i_lk_valid;
  logic [PC_W-1:0]  i_lk_pc;
  logic             o_pred_valid;
  logic             o_pred_taken;
  logic [IDX_W-1:0] o_pred_idx;
  logic [CTR_W-1:0] o_pred_ctr;
  logic             i_upd_valid;
  logic [IDX_W-1:0] i_upd_idx;
  logic             i_upd_taken;
  logic             o_ready;
  logic             o_dbg_state;

  modport master (
    output i_lk_valid, i_lk_pc, i_upd_valid, i_upd_idx, i_upd_taken,
    input  o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ctr, o_ready, o_dbg_state
  );

  modport slave (
    input  i_lk_valid, i_lk_pc, i_upd_valid, i_upd_idx, i_upd_taken,
    output o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ctr, o_ready, o_dbg_state
  );
endinterface

// File: rtl/gshare_pht_predictor.sv
// Pattern-history-table branch predictor with bimodal or gshare indexing.
// The table is swept to INIT_CTR after every reset; o_ready marks the end of the sweep.
module gshare_pht_predictor #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 6,
  parameter int CTR_W     = 2,
  parameter int GHR_W     = 6,
  parameter int HASH_MODE = 1,
  parameter int INIT_CTR  = 1
) (
  input  logic        clk,
  input  logic        rst,
  gshare_pht_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_valid_q, pred_valid_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [CTR_W-1:0] pred_ctr_q, pred_ctr_d;
  logic [CTR_W-1:0] ctr_mem [DEPTH];

  logic             run;
  logic [IDX_W-1:0] pc_idx, lk_idx;
  logic [CTR_W-1:0] upd_old, upd_new, lk_ctr;
  logic             unused_pc;

  assign run       = (state_q == S_RUN);
  assign pc_idx    = bus.i_lk_pc[IDX_W+1:2];
  assign unused_pc = ^{bus.i_lk_pc[PC_W-1:IDX_W+2], bus.i_lk_pc[1:0]};

  generate
    if (HASH_MODE == 1) begin : g_gshare
      assign lk_idx = pc_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
      logic unused_ghr;
      assign lk_idx     = pc_idx;
      assign unused_ghr = ^ghr_q;
    end
  endgenerate

  // Saturating update, plus write-first bypass so a same-index lookup sees the new value.
  always_comb begin
    upd_old = ctr_mem[bus.i_upd_idx];
    upd_new = upd_old;
    if (bus.i_upd_taken) begin
      if (upd_old != CTR_MAX) upd_new = upd_old + CTR_W'(1);
    end else begin
      if (upd_old != '0) upd_new = upd_old - CTR_W'(1);
    end
    lk_ctr = ctr_mem[lk_idx];
    if (bus.i_upd_valid && (bus.i_upd_idx == lk_idx)) lk_ctr = upd_new;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ghr_d        = ghr_q;
    pred_valid_d = 1'b0;
    pred_idx_d   = pred_idx_q;
    pred_ctr_d   = pred_ctr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.i_upd_valid) begin
          ghr_d    = ghr_q << 1;
          ghr_d[0] = bus.i_upd_taken;
        end
        if (bus.i_lk_valid) begin
          pred_valid_d = 1'b1;
          pred_idx_d   = lk_idx;
          pred_ctr_d   = lk_ctr;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_idx_q   <= '0;
      pred_ctr_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_idx_q   <= pred_idx_d;
      pred_ctr_q   <= pred_ctr_d;
    end
  end

  // Table storage has no reset; the INIT sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      ctr_mem[ptr_q] <= CTR_INIT;
    end else if (bus.i_upd_valid) begin
      ctr_mem[bus.i_upd_idx] <= upd_new;
    end
  end

  assign bus.o_pred_valid = pred_valid_q;
  assign bus.o_pred_idx   = pred_idx_q;
  assign bus.o_pred_ctr   = pred_ctr_q;
  assign bus.o_pred_taken = pred_ctr_q[CTR_W-1];
  assign bus.o_ready      = run;
  assign bus.o_dbg_state  = state_q;
endmodule

// File: tb/tb_gshare_pht_predictor.sv
// Directed bench for the gshare predictor: a gshare and a bimodal instance driven in lockstep
// against a reference table model and per-instance expected-prediction queues.
module tb_gshare_pht_predictor;
  localparam int IDX_W = 6;
  localparam int CTR_W = 2;
  localparam int DEPTH = 64;
  localparam int W     = 1 + IDX_W + CTR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_pht_if #(.PC_W(32), .IDX_W(IDX_W), .CTR_W(CTR_W)) bus_g ();
  gshare_pht_if #(.PC_W(32), .IDX_W(IDX_W), .CTR_W(CTR_W)) bus_b ();

  gshare_pht_predictor #(.PC_W(32), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(6),
                         .HASH_MODE(1), .INIT_CTR(1)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));
  gshare_pht_predictor #(.PC_W(32), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(6),
                         .HASH_MODE(0), .INIT_CTR(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_asserts = 0;
  int n_fails   = 0;

  logic [W-1:0]     exp_g[$];
  logic [W-1:0]     exp_b[$];
  logic [CTR_W-1:0] m_g [DEPTH];
  logic [CTR_W-1:0] m_b [DEPTH];
  logic [5:0]       m_ghr;
  bit               ready_exp;
  int               init_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CTR_W-1:0] sat(input logic [CTR_W-1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_g[i] = 2'd1;
      m_b[i] = 2'd1;
    end
    m_ghr = '0;
    exp_g.delete();
    exp_b.delete();
    ready_exp = 0;
    init_cnt  = 0;
  endtask

  task automatic sb_cmp(input string tag, input logic v, input logic [W-1:0] got,
                        input bit has, input logic [W-1:0] e);
    if (has) begin
      chk({tag, "_valid"}, {31'd0, v}, 32'd1);
      if (v) chk(tag, {23'd0, got}, {23'd0, e});
    end else begin
      chk({tag, "_valid"}, {31'd0, v}, 32'd0);
    end
  endtask

  // Entered and left on a falling edge: drive, update the model, clock once, check.
  task automatic drive(input logic lk_v, input logic [31:0] pc, input logic up_v,
                       input logic [5:0] ui_g, input logic [5:0] ui_b, input logic ut);
    logic [5:0]   ig, ib;
    logic [W-1:0] eg, eb;
    bit           hg, hb;
    bus_g.i_lk_valid = lk_v;  bus_b.i_lk_valid = lk_v;
    bus_g.i_lk_pc    = pc;    bus_b.i_lk_pc    = pc;
    bus_g.i_upd_valid = up_v; bus_b.i_upd_valid = up_v;
    bus_g.i_upd_idx  = ui_g;  bus_b.i_upd_idx  = ui_b;
    bus_g.i_upd_taken = ut;   bus_b.i_upd_taken = ut;
    if (ready_exp) begin
      ig = pc[7:2] ^ m_ghr;
      ib = pc[7:2];
      if (up_v) begin
        m_g[ui_g] = sat(m_g[ui_g], ut);
        m_b[ui_b] = sat(m_b[ui_b], ut);
      end
      if (lk_v) begin
        exp_g.push_back({m_g[ig][1], ig, m_g[ig]});
        exp_b.push_back({m_b[ib][1], ib, m_b[ib]});
      end
      if (up_v) m_ghr = {m_ghr[4:0], ut};
    end
    @(posedge clk);
    #1;
    if (!rst && !ready_exp) begin
      init_cnt++;
      if (init_cnt == DEPTH) ready_exp = 1;
    end
    chk("ready_g", {31'd0, bus_g.o_ready}, {31'd0, ready_exp});
    chk("ready_b", {31'd0, bus_b.o_ready}, {31'd0, ready_exp});
    hg = (exp_g.size() != 0); eg = hg ? exp_g.pop_front() : '0;
    hb = (exp_b.size() != 0); eb = hb ? exp_b.pop_front() : '0;
    sb_cmp("pred_g", bus_g.o_pred_valid, {bus_g.o_pred_taken, bus_g.o_pred_idx, bus_g.o_pred_ctr}, hg, eg);
    sb_cmp("pred_b", bus_b.o_pred_valid, {bus_b.o_pred_taken, bus_b.o_pred_idx, bus_b.o_pred_ctr}, hb, eb);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc_for_g(input logic [5:0] idx);
    logic [5:0] p;
    p = idx ^ m_ghr;
    return {24'd0, p, 2'b00};
  endfunction

  initial begin
    int sat_tbl [7];
    logic       pg, pb, t;
    logic [5:0] ig;
    int         cg, cb;
    sat_tbl = '{2, 3, 3, 2, 1, 0, 0};

    rst = 1'b1;
    bus_g.i_lk_valid = 0; bus_g.i_lk_pc = '0; bus_g.i_upd_valid = 0; bus_g.i_upd_idx = '0; bus_g.i_upd_taken = 0;
    bus_b.i_lk_valid = 0; bus_b.i_lk_pc = '0; bus_b.i_upd_valid = 0; bus_b.i_upd_idx = '0; bus_b.i_upd_taken = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus_g.o_ready}, 32'd0);
    chk("rst_valid", {31'd0, bus_g.o_pred_valid}, 32'd0);
    chk("rst_idx",   {26'd0, bus_g.o_pred_idx}, 32'd0);
    chk("rst_ctr",   {30'd0, bus_g.o_pred_ctr}, 32'd0);
    chk("rst_taken", {31'd0, bus_g.o_pred_taken}, 32'd0);
    chk("rst_state", {31'd0, bus_g.o_dbg_state}, 32'd0);

    // Init sweep with lookups and updates that must be ignored.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, $urandom_range(0, 32'hffff), 1'b1, 6'($urandom_range(0, 63)), 6'd0, 1'b1);
    chk("run_state", {31'd0, bus_g.o_dbg_state}, 32'd1);

    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'(i) << 2, 1'b0, 6'd0, 6'd0, 1'b0);

    // Saturation on entry 5.
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 32'd0, 1'b1, 6'd5, 6'd5, (k < 3));
      drive(1'b1, pc_for_g(6'd5), 1'b0, 6'd0, 6'd0, 1'b0);
      chk("sat_ctr",   {30'd0, bus_g.o_pred_ctr}, 32'(sat_tbl[k]));
      chk("sat_taken", {31'd0, bus_g.o_pred_taken}, {31'd0, sat_tbl[k] >= 2});
    end

    // Same-cycle lookup and update of entry 9.
    drive(1'b1, pc_for_g(6'd9), 1'b1, 6'd9, 6'd9, 1'b1);
    chk("byp_ctr",   {30'd0, bus_g.o_pred_ctr}, 32'd2);
    chk("byp_taken", {31'd0, bus_g.o_pred_taken}, 32'd1);

    // Flush history, then T,T,N,T gives GHR 13.
    for (int k = 0; k < 6; k++) drive(1'b0, 32'd0, 1'b1, 6'd40, 6'd40, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 6'd40, 6'd40, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 6'd40, 6'd40, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 6'd40, 6'd40, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 6'd40, 6'd40, 1'b1);
    drive(1'b1, 32'h0000_0040, 1'b0, 6'd0, 6'd0, 1'b0);
    chk("hash_idx_g", {26'd0, bus_g.o_pred_idx}, 32'd29);
    chk("hash_idx_b", {26'd0, bus_b.o_pred_idx}, 32'd16);

    // T,T,T,N loop branch at pc 0x80.
    cg = 0;
    cb = 0;
    for (int it = 0; it < 200; it++) begin
      t  = (it % 4 != 3);
      ig = 6'd32 ^ m_ghr;
      drive(1'b1, 32'h0000_0080, 1'b0, 6'd0, 6'd0, 1'b0);
      pg = bus_g.o_pred_taken;
      pb = bus_b.o_pred_taken;
      if (it >= 180) begin
        if (pg == t) cg++;
        if (pb == t) cb++;
      end
      drive(1'b0, 32'd0, 1'b1, ig, 6'd32, t);
    end
    chk("loop_g_correct", 32'(cg), 32'd20);
    chk("loop_b_correct", 32'(cb), 32'd15);

    // Asynchronous reset while a prediction is showing.
    drive(1'b1, 32'h0000_0044, 1'b0, 6'd0, 6'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, bus_g.o_pred_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus_g.o_pred_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus_g.o_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i) << 2, 1'b0, 6'd0, 6'd0, 1'b0);
      chk("reinit_idx", {26'd0, bus_g.o_pred_idx}, 32'(i));
      chk("reinit_ctr", {30'd0, bus_g.o_pred_ctr}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
